// File: rtl/sevseg_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low segment
// patterns (g..a), special digit codes and the FSM state type.
package sevseg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [3:0] ERR   = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_t;

  // One-hot digit select, or zero unless exactly one anode strobe is low.
  function automatic logic [NUM_DIGITS-1:0] digit_select(input logic [NUM_DIGITS-1:0] an);
    logic [NUM_DIGITS-1:0] sel;
    case (an)
      4'b1110: sel = 4'b0001;
      4'b1101: sel = 4'b0010;
      4'b1011: sel = 4'b0100;
      4'b0111: sel = 4'b1000;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low g..a segment pattern to a digit code.
// Unknown patterns map to the ERR code with err raised.
module seg7_to_bcd
  import sevseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = ERR;
    err  = 1'b1;
    case (seg)
      SEG_0:     begin code = 4'd0;  err = 1'b0; end
      SEG_1:     begin code = 4'd1;  err = 1'b0; end
      SEG_2:     begin code = 4'd2;  err = 1'b0; end
      SEG_3:     begin code = 4'd3;  err = 1'b0; end
      SEG_4:     begin code = 4'd4;  err = 1'b0; end
      SEG_5:     begin code = 4'd5;  err = 1'b0; end
      SEG_6:     begin code = 4'd6;  err = 1'b0; end
      SEG_7:     begin code = 4'd7;  err = 1'b0; end
      SEG_8:     begin code = 4'd8;  err = 1'b0; end
      SEG_9:     begin code = 4'd9;  err = 1'b0; end
      SEG_BLANK: begin code = BLANK; err = 1'b0; end
      default:   begin code = ERR;   err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/sevseg_scan_decoder.sv
// Recovers the displayed digits from a multiplexed 4-digit seven-segment bus
// by sampling each dwell once it is stable and publishing only complete frames.
module sevseg_scan_decoder
  import sevseg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [7:0] seg,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic [3:0] dp,
  output logic [3:0] digit_err,
  output logic       frame_valid,
  output logic       stale,
  output logic [1:0] dbg_state
);

  localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYCLES);
  localparam int         TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT_CYCLES);

  logic [3:0]  an_s1, an_s2;
  logic [7:0]  seg_s1, seg_s2;
  logic [11:0] prev_q;
  logic [7:0]  stable_q;
  scan_state_t state_q;
  logic [NUM_DIGITS-1:0] seen_q;
  logic [NUM_DIGITS-1:0][3:0] sh_code_q;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_err_q;
  logic [NUM_DIGITS-1:0][3:0] bcd_q;
  logic [TW-1:0] to_q;

  logic [11:0] sample;
  logic        changed;
  logic [NUM_DIGITS-1:0] sel;
  logic        sel_valid;
  logic [7:0]  stable_next;
  scan_state_t eff_state;
  logic        capture;
  logic        publish;
  logic [3:0]  dec_code;
  logic        dec_err;
  logic [TW-1:0] to_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1  <= 4'hF;
      an_s2  <= 4'hF;
      seg_s1 <= 8'hFF;
      seg_s2 <= 8'hFF;
    end else begin
      an_s1  <= an;
      an_s2  <= an_s1;
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
    end
  end

  seg7_to_bcd u_dec (
    .seg  (seg_s2[6:0]),
    .code (dec_code),
    .err  (dec_err)
  );

  // A bus change overrides the current state before the settle check, so a
  // single-sample settle still captures on the first cycle of a new dwell.
  always_comb begin
    sample      = {an_s2, seg_s2};
    changed     = (sample != prev_q);
    sel         = digit_select(an_s2);
    sel_valid   = |sel;
    stable_next = changed ? 8'd1 : ((stable_q == 8'hFF) ? stable_q : stable_q + 8'd1);
    eff_state   = state_q;
    if (changed) eff_state = sel_valid ? ST_SETTLE : ST_IDLE;
    capture     = sel_valid && (eff_state == ST_SETTLE) && (stable_next >= SETTLE_LIM);
    publish     = (seen_q == {NUM_DIGITS{1'b1}});
    to_next     = publish ? '0 : ((to_q >= TO_LIM) ? to_q : to_q + 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prev_q   <= 12'hFFF;
      stable_q <= 8'd0;
    end else begin
      prev_q   <= sample;
      stable_q <= stable_next;
      state_q  <= capture ? ST_HELD : eff_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q    <= '0;
      sh_code_q <= {NUM_DIGITS{BLANK}};
      sh_dp_q   <= '0;
      sh_err_q  <= '0;
    end else begin
      seen_q <= (publish ? '0 : seen_q) | (capture ? sel : '0);
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (capture && sel[k]) begin
          sh_code_q[k] <= dec_code;
          sh_dp_q[k]   <= ~seg_s2[7];
          sh_err_q[k]  <= dec_err;
        end
      end
    end
  end

  // stale is registered from the next count so it always equals (to_q >= limit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q       <= {NUM_DIGITS{BLANK}};
      dp          <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      to_q        <= '0;
      stale       <= 1'b0;
    end else begin
      frame_valid <= publish;
      to_q        <= to_next;
      stale       <= (to_next >= TO_LIM);
      if (publish) begin
        bcd_q     <= sh_code_q;
        dp        <= sh_dp_q;
        digit_err <= sh_err_q;
      end
    end
  end

  assign bcd0      = bcd_q[0];
  assign bcd1      = bcd_q[1];
  assign bcd2      = bcd_q[2];
  assign bcd3      = bcd_q[3];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
// Bench for sevseg_scan_decoder: drives scanned digit dwells and compares each
// published frame against an expected-frame queue.
module tb_sevseg_scan_decoder;
  import sevseg_pkg::*;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 200;
  localparam int W       = 24;
  localparam int DWELL   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] an = 4'hF;
  logic [7:0] seg = 8'hFF;
  logic [3:0] bcd0, bcd1, bcd2, bcd3, dp, digit_err;
  logic       frame_valid, stale;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;
  int cyc = 0;
  int last_fv_cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_v, exp_v;

  sevseg_scan_decoder #(
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .seg         (seg),
    .bcd0        (bcd0),
    .bcd1        (bcd1),
    .bcd2        (bcd2),
    .bcd3        (bcd3),
    .dp          (dp),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .stale       (stale),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500_000;
    $display("FAIL watchdog: got time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every published frame must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && frame_valid) begin
      frame_cnt++;
      last_fv_cyc = cyc;
      got_v = {bcd3, bcd2, bcd1, bcd0, dp, digit_err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got %h, expected no frame", got_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL frame_data: got %h, expected %h", got_v, exp_v);
        end
      end
      checks++;
      if (stale !== 1'b0) begin
        errors++;
        $display("FAIL stale_at_publish: got %b, expected 0", stale);
      end
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] code);
    case (code)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      4'hF: return 7'h7F;
      default: return 7'h55;
    endcase
  endfunction

  task automatic push_exp(input logic [15:0] digits, input logic [3:0] dp_on);
    logic [3:0] e;
    for (int k = 0; k < 4; k++) e[k] = (digits[4*k +: 4] == 4'hE);
    exp_q.push_back({digits, dp_on, e});
  endtask

  task automatic drive_digit(input int idx, input logic [3:0] code, input logic dp_on, input int dwell);
    an = 4'hF;
    an[idx] = 1'b0;
    seg = {~dp_on, seg_of(code)};
    repeat (dwell) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [15:0] digits, input logic [3:0] dp_on);
    for (int k = 3; k >= 0; k--) drive_digit(k, digits[4*k +: 4], dp_on[k], DWELL);
  endtask

  task automatic idle_bus(input int n);
    an = 4'hF;
    seg = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({bcd3, bcd2, bcd1, bcd0} !== 16'hFFFF) begin
      errors++;
      $display("FAIL %s_bcd: got %h, expected ffff", tag, {bcd3, bcd2, bcd1, bcd0});
    end
    checks++;
    if ({dp, digit_err, frame_valid, stale} !== 10'd0) begin
      errors++;
      $display("FAIL %s_flags: got dp=%b err=%b fv=%b stale=%b, expected all 0",
               tag, dp, digit_err, frame_valid, stale);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL %s_state: got %0d, expected 0", tag, dbg_state);
    end
  endtask

  task automatic test_reset();
    check_reset_values("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset_release");
  endtask

  task automatic test_scan_1200();
    int f0 = frame_cnt;
    push_exp(16'h1200, 4'b0000);
    drive_digit(3, 4'd1, 1'b0, DWELL);
    checks++;
    if (dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL scan_held_state: got %0d, expected 2", dbg_state);
    end
    drive_digit(2, 4'd2, 1'b0, DWELL);
    drive_digit(1, 4'd0, 1'b0, DWELL);
    drive_digit(0, 4'd0, 1'b0, DWELL);
    idle_bus(8);
    checks++;
    if (frame_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL scan_frame_count: got %0d, expected 1", frame_cnt - f0);
    end
  endtask

  task automatic test_short_dwell();
    int f0 = frame_cnt;
    drive_digit(0, 4'd7, 1'b0, SETTLE - 1);
    drive_digit(1, 4'd4, 1'b0, DWELL);
    drive_digit(2, 4'd5, 1'b0, DWELL);
    drive_digit(3, 4'd6, 1'b0, DWELL);
    idle_bus(8);
    checks++;
    if (frame_cnt !== f0) begin
      errors++;
      $display("FAIL short_no_frame: got %0d frames, expected 0", frame_cnt - f0);
    end
    checks++;
    if ({bcd3, bcd2, bcd1, bcd0} !== 16'h1200) begin
      errors++;
      $display("FAIL short_hold: got %h, expected 1200", {bcd3, bcd2, bcd1, bcd0});
    end
    push_exp(16'h6547, 4'b0000);
    drive_digit(0, 4'd7, 1'b0, SETTLE);
    idle_bus(8);
    checks++;
    if (frame_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL short_complete: got %0d frames, expected 1", frame_cnt - f0);
    end
  endtask

  task automatic test_blank_err();
    push_exp(16'hFE38, 4'b0000);
    drive_frame(16'hFE38, 4'b0000);
    idle_bus(8);
    checks++;
    if (digit_err !== 4'b0100) begin
      errors++;
      $display("FAIL blank_err_flags: got %b, expected 0100", digit_err);
    end
  endtask

  task automatic test_dp();
    push_exp(16'h7596, 4'b0001);
    drive_digit(0, 4'd6, 1'b1, DWELL);
    drive_digit(2, 4'd5, 1'b0, DWELL);
    drive_digit(1, 4'd9, 1'b0, DWELL);
    drive_digit(3, 4'd7, 1'b0, DWELL);
    idle_bus(8);
    checks++;
    if (dp !== 4'b0001) begin
      errors++;
      $display("FAIL dp_digit0: got %b, expected 0001", dp);
    end
  endtask

  task automatic test_back_to_back();
    int f0 = frame_cnt;
    logic [15:0] d;
    logic [3:0]  p;
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 4; k++) d[4*k +: 4] = 4'($urandom_range(0, 9));
      p = 4'($urandom_range(0, 15));
      push_exp(d, p);
      for (int k = 3; k >= 0; k--)
        drive_digit(k, d[4*k +: 4], p[k], $urandom_range(SETTLE, 12));
    end
    idle_bus(8);
    checks++;
    if (frame_cnt - f0 !== 5) begin
      errors++;
      $display("FAIL b2b_frame_count: got %0d, expected 5", frame_cnt - f0);
    end
  endtask

  task automatic test_timeout();
    int f0;
    int rise = -1;
    push_exp(16'h0421, 4'b1000);
    drive_frame(16'h0421, 4'b1000);
    idle_bus(1);
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b, expected 0", stale);
    end
    for (int n = 0; n < 2 * TIMEOUT; n++) begin
      if (stale) begin
        rise = cyc - last_fv_cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (rise !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout_rise: got %0d cycles, expected %0d", rise, TIMEOUT);
    end
    repeat (TIMEOUT) @(negedge clk);
    checks++;
    if (stale !== 1'b1) begin
      errors++;
      $display("FAIL timeout_saturate: got %b, expected 1", stale);
    end
    f0 = frame_cnt;
    push_exp(16'h9999, 4'b0000);
    drive_frame(16'h9999, 4'b0000);
    idle_bus(4);
    checks++;
    if (frame_cnt - f0 !== 1 || stale !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: got frames=%0d stale=%b, expected 1 and 0", frame_cnt - f0, stale);
    end
  endtask

  task automatic test_reset_midframe();
    int f0 = frame_cnt;
    drive_digit(3, 4'd3, 1'b0, DWELL);
    drive_digit(2, 4'd1, 1'b0, DWELL);
    drive_digit(1, 4'd4, 1'b0, DWELL);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midframe_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_digit(0, 4'd5, 1'b0, DWELL);
    idle_bus(8);
    checks++;
    if (frame_cnt !== f0) begin
      errors++;
      $display("FAIL midframe_partial: got %0d frames, expected 0", frame_cnt - f0);
    end
    push_exp(16'h3145, 4'b0000);
    drive_frame(16'h3145, 4'b0000);
    idle_bus(8);
    checks++;
    if (frame_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL midframe_full: got %0d frames, expected 1", frame_cnt - f0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_scan_1200();
    test_short_dwell();
    test_blank_err();
    test_dp();
    test_back_to_back();
    test_timeout();
    test_reset_midframe();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
